// File: rtl/srpt_pkg.sv
// srpt_pkg
//   Shared widths, record layouts and helpers for the SRPT grant sender.
//   Record layouts, MSB first:
//     sendmsg  : {peer_id, rpc_id, msg_len, unsched}
//     grant    : {peer_id, rpc_id, grant_offset}
//     data_pkt : {peer_id, rpc_id, offset, length}
package srpt_pkg;

   localparam int PEER_ID_W = 14;
   localparam int RPC_ID_W  = 14;
   localparam int OFFSET_W  = 32;
   localparam int PKTLEN_W  = 16;

   localparam int SENDMSG_W  = PEER_ID_W + RPC_ID_W + 2 * OFFSET_W;
   localparam int GRANT_W    = PEER_ID_W + RPC_ID_W + OFFSET_W;
   localparam int DATA_PKT_W = PEER_ID_W + RPC_ID_W + OFFSET_W + PKTLEN_W;

   localparam int SM_UNSCHED_LSB = 0;
   localparam int SM_MSG_LEN_LSB = SM_UNSCHED_LSB + OFFSET_W;
   localparam int SM_RPC_LSB     = SM_MSG_LEN_LSB + OFFSET_W;
   localparam int SM_PEER_LSB    = SM_RPC_LSB + RPC_ID_W;

   localparam int GR_OFFSET_LSB  = 0;
   localparam int GR_RPC_LSB     = GR_OFFSET_LSB + OFFSET_W;
   localparam int GR_PEER_LSB    = GR_RPC_LSB + RPC_ID_W;

   localparam int DP_LEN_LSB     = 0;
   localparam int DP_OFFSET_LSB  = DP_LEN_LSB + PKTLEN_W;
   localparam int DP_RPC_LSB     = DP_OFFSET_LSB + OFFSET_W;
   localparam int DP_PEER_LSB    = DP_RPC_LSB + RPC_ID_W;

   function automatic logic [OFFSET_W-1:0] min_off(input logic [OFFSET_W-1:0] a,
                                                   input logic [OFFSET_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [OFFSET_W-1:0] max_off(input logic [OFFSET_W-1:0] a,
                                                   input logic [OFFSET_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/srpt_sender_select.sv
// srpt_sender_select
//   Combinational argmin over the message table: among eligible slots, find the
//   one with the smallest remaining byte count. Pairwise reduction tree; on equal
//   remaining counts the lower slot index wins.
//   Ports:
//     eligible   in   SLOTS          slot may send now
//     remaining  in   SLOTS x VAL_W  bytes left in each slot's message
//     found      out  1              at least one slot eligible
//     slot_idx   out  log2(SLOTS)    winning slot (0 when nothing found)
module srpt_sender_select #(
   parameter int SLOTS = 8,
   parameter int VAL_W = 32
) (
   input  logic [SLOTS-1:0]             eligible,
   input  logic [SLOTS-1:0][VAL_W-1:0]  remaining,
   output logic                         found,
   output logic [$clog2(SLOTS)-1:0]     slot_idx
);

   localparam int IDX_W = $clog2(SLOTS);

   always_comb begin : tree
      logic             v  [SLOTS];
      logic [VAL_W-1:0] r  [SLOTS];
      logic [IDX_W-1:0] ix [SLOTS];
      for (int i = 0; i < SLOTS; i++) begin
         v[i]  = eligible[i];
         r[i]  = remaining[i];
         ix[i] = IDX_W'(i);
      end
      // Each level folds the right-hand partner into the left node; the strict
      // compare keeps the lower index on ties.
      for (int step = 1; step < SLOTS; step = step * 2) begin
         for (int i = 0; i + step < SLOTS; i = i + 2 * step) begin
            if (v[i+step] && (!v[i] || (r[i+step] < r[i]))) begin
               v[i]  = 1'b1;
               r[i]  = r[i+step];
               ix[i] = ix[i+step];
            end
         end
      end
      found    = v[0];
      slot_idx = ix[0];
   end

endmodule

// File: rtl/srpt_grant_sender.sv
// srpt_grant_sender
//   Sender-side SRPT scheduler. Holds an outbound message table indexed by the
//   low rpc_id bits, raises per-message granted offsets from incoming grants and
//   issues at most one data-packet request per cycle to the message with the
//   fewest remaining bytes, never past its granted offset.
//   Build option: GRANT_SENDER_STATS_EN enables the dropped-grant and sent-packet
//   counters; without it both counter outputs are tied to zero.
//   Ports:
//     ap_clk, ap_rst                       clock, async active-high reset
//     sendmsg_empty_i/read_en_o/data_i     sendmsg FIFO (FWFT)
//     grant_pkt_empty_i/read_en_o/data_i   grant FIFO (FWFT), popped whenever non-empty
//     data_pkt_full_i                      TX FIFO almost-full
//     data_pkt_write_en_o/data_o           registered TX FIFO push
//     dropped_grants_o, pkts_sent_o        statistics counters
module srpt_grant_sender
   import srpt_pkg::*;
#(
   parameter int SLOTS   = 8,
   parameter int PAYLOAD = 1024
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic                   sendmsg_empty_i,
   output logic                   sendmsg_read_en_o,
   input  logic [SENDMSG_W-1:0]   sendmsg_data_i,
   input  logic                   grant_pkt_empty_i,
   output logic                   grant_pkt_read_en_o,
   input  logic [GRANT_W-1:0]     grant_pkt_data_i,
   input  logic                   data_pkt_full_i,
   output logic                   data_pkt_write_en_o,
   output logic [DATA_PKT_W-1:0]  data_pkt_data_o,
   output logic [31:0]            dropped_grants_o,
   output logic [31:0]            pkts_sent_o
);

   localparam int                  IDX_W     = $clog2(SLOTS);
   localparam logic [OFFSET_W-1:0] PAYLOAD_B = OFFSET_W'(PAYLOAD);

   logic                  valid   [SLOTS];
   logic [PEER_ID_W-1:0]  peer_id [SLOTS];
   logic [RPC_ID_W-1:0]   rpc_id  [SLOTS];
   logic [OFFSET_W-1:0]   msg_len [SLOTS];
   logic [OFFSET_W-1:0]   sent    [SLOTS];
   logic [OFFSET_W-1:0]   granted [SLOTS];

   logic [PEER_ID_W-1:0]  sm_peer;
   logic [RPC_ID_W-1:0]   sm_rpc;
   logic [OFFSET_W-1:0]   sm_len;
   logic [OFFSET_W-1:0]   sm_unsched;
   logic [IDX_W-1:0]      sm_idx;
   logic                  sm_load;

   logic [PEER_ID_W-1:0]  gr_peer;
   logic [RPC_ID_W-1:0]   gr_rpc;
   logic [OFFSET_W-1:0]   gr_offset;
   logic [IDX_W-1:0]      gr_idx;
   logic                  grant_hit;

   logic [SLOTS-1:0]                eligible;
   logic [SLOTS-1:0][OFFSET_W-1:0]  remaining;
   logic                            found;
   logic [IDX_W-1:0]                sel;
   logic                            issue;
   logic [PKTLEN_W-1:0]             pkt_len;
   logic [OFFSET_W-1:0]             sent_next;

   assign sm_peer    = sendmsg_data_i[SM_PEER_LSB    +: PEER_ID_W];
   assign sm_rpc     = sendmsg_data_i[SM_RPC_LSB     +: RPC_ID_W];
   assign sm_len     = sendmsg_data_i[SM_MSG_LEN_LSB +: OFFSET_W];
   assign sm_unsched = sendmsg_data_i[SM_UNSCHED_LSB +: OFFSET_W];
   assign sm_idx     = sm_rpc[IDX_W-1:0];

   assign gr_peer    = grant_pkt_data_i[GR_PEER_LSB   +: PEER_ID_W];
   assign gr_rpc     = grant_pkt_data_i[GR_RPC_LSB    +: RPC_ID_W];
   assign gr_offset  = grant_pkt_data_i[GR_OFFSET_LSB +: OFFSET_W];
   assign gr_idx     = gr_rpc[IDX_W-1:0];

   // Head-of-line: a sendmsg whose slot is busy waits; a zero-length message is
   // popped but never occupies the table.
   assign sendmsg_read_en_o   = !sendmsg_empty_i && !valid[sm_idx];
   assign sm_load             = sendmsg_read_en_o && (sm_len != '0);
   assign grant_pkt_read_en_o = !grant_pkt_empty_i;
   assign grant_hit           = grant_pkt_read_en_o && valid[gr_idx] &&
                                (rpc_id[gr_idx] == gr_rpc) && (peer_id[gr_idx] == gr_peer);

   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         eligible[i]  = valid[i] && (sent[i] < granted[i]);
         remaining[i] = msg_len[i] - sent[i];
      end
   end

   srpt_sender_select #(
      .SLOTS (SLOTS),
      .VAL_W (OFFSET_W)
   ) u_select (
      .eligible  (eligible),
      .remaining (remaining),
      .found     (found),
      .slot_idx  (sel)
   );

   assign issue     = found && !data_pkt_full_i;
   assign pkt_len   = PKTLEN_W'(min_off(PAYLOAD_B, granted[sel] - sent[sel]));
   assign sent_next = sent[sel] + OFFSET_W'(pkt_len);

   // The loaded slot was invalid at cycle start, so it never coincides with the
   // issuing or granted slot; grant and issue on one slot touch disjoint fields.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            valid[i]   <= 1'b0;
            peer_id[i] <= '0;
            rpc_id[i]  <= '0;
            msg_len[i] <= '0;
            sent[i]    <= '0;
            granted[i] <= '0;
         end
         data_pkt_write_en_o <= 1'b0;
         data_pkt_data_o     <= '0;
      end else begin
         data_pkt_write_en_o <= issue;
         if (issue) begin
            data_pkt_data_o[DP_PEER_LSB   +: PEER_ID_W] <= peer_id[sel];
            data_pkt_data_o[DP_RPC_LSB    +: RPC_ID_W]  <= rpc_id[sel];
            data_pkt_data_o[DP_OFFSET_LSB +: OFFSET_W]  <= sent[sel];
            data_pkt_data_o[DP_LEN_LSB    +: PKTLEN_W]  <= pkt_len;
            sent[sel] <= sent_next;
            if (sent_next == msg_len[sel]) begin
               valid[sel] <= 1'b0;
            end
         end
         if (grant_hit) begin
            granted[gr_idx] <= max_off(granted[gr_idx], min_off(gr_offset, msg_len[gr_idx]));
         end
         if (sm_load) begin
            valid[sm_idx]   <= 1'b1;
            peer_id[sm_idx] <= sm_peer;
            rpc_id[sm_idx]  <= sm_rpc;
            msg_len[sm_idx] <= sm_len;
            sent[sm_idx]    <= '0;
            granted[sm_idx] <= min_off(sm_unsched, sm_len);
         end
      end
   end

`ifdef GRANT_SENDER_STATS_EN
   logic [31:0] dropped_cnt;
   logic [31:0] sent_cnt;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         dropped_cnt <= '0;
         sent_cnt    <= '0;
      end else begin
         if (grant_pkt_read_en_o && !grant_hit) begin
            dropped_cnt <= dropped_cnt + 32'd1;
         end
         if (issue) begin
            sent_cnt <= sent_cnt + 32'd1;
         end
      end
   end

   assign dropped_grants_o = dropped_cnt;
   assign pkts_sent_o      = sent_cnt;
`else
   assign dropped_grants_o = '0;
   assign pkts_sent_o      = '0;
`endif

endmodule

// File: tb/tb_srpt_grant_sender.sv
// tb_srpt_grant_sender
//   Drives FWFT sendmsg/grant queues and a random almost-full into the sender and
//   compares every output each cycle against a slot-table model that applies the
//   scheduling rules directly (linear min search, plain arithmetic). Directed
//   scenarios pin the model's packet log to hand-computed values.
module tb_srpt_grant_sender;

   localparam int SLOTS   = 8;
   localparam int PAYLOAD = 1024;
`ifdef GRANT_SENDER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          ap_clk = 1'b0;
   logic          ap_rst;
   logic          sendmsg_empty_i;
   logic          sendmsg_read_en_o;
   logic [91:0]   sendmsg_data_i;
   logic          grant_pkt_empty_i;
   logic          grant_pkt_read_en_o;
   logic [59:0]   grant_pkt_data_i;
   logic          data_pkt_full_i;
   logic          data_pkt_write_en_o;
   logic [75:0]   data_pkt_data_o;
   logic [31:0]   dropped_grants_o;
   logic [31:0]   pkts_sent_o;

   always #5 ap_clk = ~ap_clk;

   srpt_grant_sender #(.SLOTS(SLOTS), .PAYLOAD(PAYLOAD)) dut (
      .ap_clk              (ap_clk),
      .ap_rst              (ap_rst),
      .sendmsg_empty_i     (sendmsg_empty_i),
      .sendmsg_read_en_o   (sendmsg_read_en_o),
      .sendmsg_data_i      (sendmsg_data_i),
      .grant_pkt_empty_i   (grant_pkt_empty_i),
      .grant_pkt_read_en_o (grant_pkt_read_en_o),
      .grant_pkt_data_i    (grant_pkt_data_i),
      .data_pkt_full_i     (data_pkt_full_i),
      .data_pkt_write_en_o (data_pkt_write_en_o),
      .data_pkt_data_o     (data_pkt_data_o),
      .dropped_grants_o    (dropped_grants_o),
      .pkts_sent_o         (pkts_sent_o)
   );

   typedef struct { int unsigned peer; int unsigned rpc; int unsigned len; int unsigned uns; } smsg_t;
   typedef struct { int unsigned peer; int unsigned rpc; int unsigned off; } grant_t;
   typedef struct { int unsigned peer; int unsigned rpc; int unsigned off; int unsigned len; } pkt_t;

   smsg_t  sq[$];
   grant_t gq[$];
   pkt_t   plog[$];

   bit          m_valid [SLOTS];
   int unsigned m_peer  [SLOTS];
   int unsigned m_rpc   [SLOTS];
   int unsigned m_len   [SLOTS];
   int unsigned m_sent  [SLOTS];
   int unsigned m_gr    [SLOTS];
   bit          m_we;
   pkt_t        m_pkt;
   int unsigned m_drop;
   int unsigned m_cnt;
   bit          full;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < SLOTS; i++) begin
         m_valid[i] = 1'b0;
         m_sent[i]  = 0;
         m_gr[i]    = 0;
      end
      m_we   = 1'b0;
      m_drop = 0;
      m_cnt  = 0;
      sq.delete();
      gq.delete();
   endtask

   task automatic drive();
      sendmsg_empty_i   = (sq.size() == 0);
      sendmsg_data_i    = '0;
      if (sq.size() != 0)
         sendmsg_data_i = {14'(sq[0].peer), 14'(sq[0].rpc), sq[0].len, sq[0].uns};
      grant_pkt_empty_i = (gq.size() == 0);
      grant_pkt_data_i  = '0;
      if (gq.size() != 0)
         grant_pkt_data_i = {14'(gq[0].peer), 14'(gq[0].rpc), gq[0].off};
      data_pkt_full_i   = full;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle();
      bit          srd, grd, issue, ghit;
      int          sel;
      int unsigned s, ln, lim;
      grant_t      g;
      smsg_t       m;
      drive();
      srd = (sq.size() != 0) && !m_valid[sq[0].rpc % SLOTS];
      grd = (gq.size() != 0);
      #1;
      chk("sendmsg_read_en", sendmsg_read_en_o, srd);
      chk("grant_read_en", grant_pkt_read_en_o, grd);
      sel = -1;
      for (int i = 0; i < SLOTS; i++)
         if (m_valid[i] && m_sent[i] < m_gr[i])
            if (sel < 0 || (m_len[i] - m_sent[i]) < (m_len[sel] - m_sent[sel])) sel = i;
      issue = (sel >= 0) && !full;
      ghit  = 1'b0;
      s     = 0;
      if (grd) begin
         s    = gq[0].rpc % SLOTS;
         ghit = m_valid[s] && m_rpc[s] == gq[0].rpc && m_peer[s] == gq[0].peer;
      end
      @(posedge ap_clk);
      m_we = issue;
      if (issue) begin
         ln    = m_gr[sel] - m_sent[sel];
         if (ln > PAYLOAD) ln = PAYLOAD;
         m_pkt = '{m_peer[sel], m_rpc[sel], m_sent[sel], ln};
         plog.push_back(m_pkt);
         m_sent[sel] += ln;
         m_cnt++;
         if (m_sent[sel] == m_len[sel]) m_valid[sel] = 1'b0;
      end
      if (grd) begin
         g = gq.pop_front();
         if (ghit) begin
            lim = (g.off < m_len[s]) ? g.off : m_len[s];
            if (lim > m_gr[s]) m_gr[s] = lim;
         end else begin
            m_drop++;
         end
      end
      if (srd) begin
         m = sq.pop_front();
         if (m.len != 0) begin
            s          = m.rpc % SLOTS;
            m_valid[s] = 1'b1;
            m_peer[s]  = m.peer;
            m_rpc[s]   = m.rpc;
            m_len[s]   = m.len;
            m_sent[s]  = 0;
            m_gr[s]    = (m.uns < m.len) ? m.uns : m.len;
         end
      end
      @(negedge ap_clk);
      chk("write_en", data_pkt_write_en_o, m_we);
      if (m_we)
         chk("pkt_data", data_pkt_data_o,
             {14'(m_pkt.peer), 14'(m_pkt.rpc), m_pkt.off, 16'(m_pkt.len)});
      chk("dropped_grants", dropped_grants_o, STATS ? m_drop : 0);
      chk("pkts_sent", pkts_sent_o, STATS ? m_cnt : 0);
   endtask

   task automatic chk_pkt(input string name, input int idx, input int unsigned rpc,
                          input int unsigned off, input int unsigned len);
      pkt_t p;
      p = '{0, 0, 32'hffff_ffff, 0};
      if (idx < plog.size()) p = plog[idx];
      chk(name, {p.rpc, p.off, p.len}, {rpc, off, len});
   endtask

   initial begin
      int n;
      bit live;
      grant_t g;
      ap_rst = 1'b1;
      full   = 1'b0;
      model_clear();
      drive();
      @(negedge ap_clk);
      chk("reset_write_en", data_pkt_write_en_o, 0);
      chk("reset_data", data_pkt_data_o, 0);
      chk("reset_dropped", dropped_grants_o, 0);
      chk("reset_pkts", pkts_sent_o, 0);
      @(negedge ap_clk);
      ap_rst = 1'b0;

      // unscheduled bytes only
      sq.push_back('{1, 1, 3000, 1000});
      repeat (6) cycle();
      chk("t1_count", plog.size(), 1);
      chk_pkt("t1_pkt0", 0, 1, 0, 1000);

      // grant past message end clamps to msg_len
      gq.push_back('{1, 1, 5000});
      repeat (6) cycle();
      chk("t2_count", plog.size(), 3);
      chk_pkt("t2_pkt1", 1, 1, 1000, 1024);
      chk_pkt("t2_pkt2", 2, 1, 2024, 976);
      chk("t2_slot_free", m_valid[1], 0);

      // shortest remaining first
      full = 1'b1;
      sq.push_back('{1, 2, 4096, 4096});
      sq.push_back('{1, 3, 512, 512});
      repeat (4) cycle();
      full = 1'b0;
      repeat (8) cycle();
      chk("t3_count", plog.size(), 8);
      chk_pkt("t3_short", 3, 3, 0, 512);
      for (int k = 0; k < 4; k++) chk_pkt("t3_long", 4 + k, 2, 1024 * k, 1024);

      // back-pressure
      full = 1'b1;
      sq.push_back('{1, 4, 2000, 2000});
      repeat (2) cycle();
      n = plog.size();
      repeat (10) cycle();
      chk("t4_held", plog.size(), n);
      full = 1'b0;
      cycle();
      chk("t4_release", plog.size(), n + 1);
      chk_pkt("t4_first", n, 4, 0, 1024);
      repeat (4) cycle();

      // grant to nothing
      n = plog.size();
      gq.push_back('{1, 5, 100});
      repeat (3) cycle();
      chk("t5_dropped", m_drop, 1);
      chk("t5_no_pkt", plog.size(), n);

      // same-slot sendmsg stalls behind the live message
      full = 1'b1;
      sq.push_back('{2, 1, 3000, 3000});
      sq.push_back('{2, 9, 100, 100});
      repeat (6) cycle();
      chk("t6_stalled", sq.size(), 1);
      n = plog.size();
      full = 1'b0;
      repeat (8) cycle();
      chk("t6_count", plog.size(), n + 4);
      chk_pkt("t6_a", n,     1, 0,    1024);
      chk_pkt("t6_b", n + 1, 1, 1024, 1024);
      chk_pkt("t6_c", n + 2, 1, 2048, 952);
      chk_pkt("t6_r9", n + 3, 9, 0,   100);

      // randomized traffic
      for (int c = 0; c < 2500; c++) begin
         if (sq.size() < 4 && $urandom_range(0, 3) == 0) begin
            smsg_t m;
            m.peer = $urandom_range(0, 3);
            m.rpc  = $urandom_range(0, 15);
            m.len  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5000);
            m.uns  = $urandom_range(0, 6000);
            sq.push_back(m);
         end
         if (gq.size() < 4 && $urandom_range(0, 2) == 0) begin
            int s;
            s = $urandom_range(0, SLOTS - 1);
            if (m_valid[s]) begin
               g.rpc  = m_rpc[s];
               g.peer = ($urandom_range(0, 7) == 0) ? (m_peer[s] ^ 1) : m_peer[s];
               g.off  = $urandom_range(0, m_len[s] + 600);
            end else begin
               g.rpc  = $urandom_range(0, 15);
               g.peer = $urandom_range(0, 3);
               g.off  = $urandom_range(0, 6000);
            end
            gq.push_back(g);
         end
         full = ($urandom_range(0, 3) == 0);
         cycle();
      end

      // drain with full grants
      full = 1'b0;
      live = 1'b1;
      for (int c = 0; c < 800 && live; c++) begin
         if (gq.size() == 0)
            for (int i = 0; i < SLOTS; i++)
               if (m_valid[i]) gq.push_back('{m_peer[i], m_rpc[i], m_len[i]});
         cycle();
         live = (sq.size() != 0) || (gq.size() != 0);
         for (int i = 0; i < SLOTS; i++) if (m_valid[i]) live = 1'b1;
      end
      chk("drain_done", live, 0);

      // asynchronous reset with a packet in flight
      sq.push_back('{3, 6, 5000, 5000});
      for (int k = 0; k < 20 && !m_we; k++) cycle();
      chk("rst_setup_we", m_we, 1);
      #2 ap_rst = 1'b1;
      #1;
      chk("rst_mid_write_en", data_pkt_write_en_o, 0);
      chk("rst_mid_data", data_pkt_data_o, 0);
      chk("rst_mid_dropped", dropped_grants_o, 0);
      chk("rst_mid_pkts", pkts_sent_o, 0);
      model_clear();
      drive();
      @(negedge ap_clk);
      ap_rst = 1'b0;
      sq.push_back('{0, 14, 8, 8});
      repeat (4) cycle();
      chk("post_rst_pkt", plog[plog.size() - 1].rpc, 14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
